// File: rtl/fft_frame_buffer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package : fft_frame_pkg                                               |
// | Shared types and default sizes for the FFT frame buffer.              |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
package fft_frame_pkg;

   localparam int DEF_DATA_W   = 24;
   localparam int DEF_N_POINTS = 16;

   // Channel selection applied by the mixer stage
   typedef enum logic [1:0] {
      CH_LEFT     = 2'd0,
      CH_RIGHT    = 2'd1,
      CH_MIX      = 2'd2,
      CH_LEFT_ALT = 2'd3
   } ch_mode_t;

   // Life cycle of each ping-pong bank
   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } bank_state_t;

endpackage : fft_frame_pkg
`default_nettype wire

// File: rtl/fft_frame_buffer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Interface : fft_frame_buffer_if                                       |
// | Sample-in / frame-out bundle of the FFT frame buffer.                 |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
interface fft_frame_buffer_if
   import fft_frame_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int N_POINTS = DEF_N_POINTS,
   parameter int SEQ_W    = 8,
   parameter int DROP_W   = 16
);
   localparam int LVL_W = $clog2(N_POINTS) + 1;

   logic                         in_valid;
   logic [DATA_W-1:0]            in_left;
   logic [DATA_W-1:0]            in_right;
   logic [1:0]                   ch_mode;
   logic                         overlap_en;
   logic                         frame_ready;
   logic                         frame_valid;
   logic [N_POINTS*DATA_W-1:0]   frame_data;
   logic [SEQ_W-1:0]             frame_seq;
   logic                         overflow;
   logic [DROP_W-1:0]            drop_count;
   logic [LVL_W-1:0]             fill_level;

   // Sample source / frame consumer side
   modport master (
      output in_valid, in_left, in_right, ch_mode, overlap_en, frame_ready,
      input  frame_valid, frame_data, frame_seq, overflow, drop_count, fill_level
   );

   // Frame buffer side
   modport slave (
      input  in_valid, in_left, in_right, ch_mode, overlap_en, frame_ready,
      output frame_valid, frame_data, frame_seq, overflow, drop_count, fill_level
   );

endinterface : fft_frame_buffer_if
`default_nettype wire

// File: rtl/fft_frame_buffer_channel_mixer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : channel_mixer                                                |
// | Registered stereo-to-mono selection: left, right or floor((L+R)/2).   |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module channel_mixer
   import fft_frame_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_left,
   input  logic [DATA_W-1:0] i_right,
   input  logic [1:0]        i_mode,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_sample
);

   logic signed [DATA_W:0] w_sum;
   logic [DATA_W-1:0]      w_mixed;
   logic [DATA_W-1:0]      w_sel;
   logic                   r_valid;
   logic [DATA_W-1:0]      r_sample;

   // One extra bit keeps L+R exact; the arithmetic shift floors the average
   always_comb begin
      w_sum   = $signed({i_left[DATA_W-1], i_left}) + $signed({i_right[DATA_W-1], i_right});
      w_mixed = DATA_W'(w_sum >>> 1);
      w_sel   = i_left;
      case (ch_mode_t'(i_mode))
         CH_RIGHT: w_sel = i_right;
         CH_MIX:   w_sel = w_mixed;
         default:  w_sel = i_left;
      endcase
   end

   // Mode is applied per sample; result appears one cycle later
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_sample <= '0;
      end else begin
         r_valid  <= i_valid;
         r_sample <= w_sel;
      end
   end

   assign o_valid  = r_valid;
   assign o_sample = r_sample;

endmodule : channel_mixer
`default_nettype wire

// File: rtl/fft_frame_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : fft_frame_buffer                                             |
// | Ping-pong N-point frame collector with optional 50% overlap and       |
// | overflow accounting, feeding the FFT core.                            |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module fft_frame_buffer
   import fft_frame_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int N_POINTS = DEF_N_POINTS,
   parameter int SEQ_W    = 8,
   parameter int DROP_W   = 16
)(
   input  logic              Clk,
   input  logic              Reset,
   fft_frame_buffer_if.slave bus
);

   localparam int IDX_W = $clog2(N_POINTS);
   localparam int LVL_W = IDX_W + 1;
   localparam int HALF  = N_POINTS / 2;

   logic                        w_mix_valid;
   logic [DATA_W-1:0]           w_mix_sample;

   logic [DATA_W-1:0]           r_bank [2][N_POINTS];
   bank_state_t                 r_state [2];
   logic                        r_wr_ptr;
   logic                        r_rd_ptr;
   logic                        r_pending;
   logic [LVL_W-1:0]            r_wr_idx;
   logic [SEQ_W-1:0]            r_seq;
   logic                        r_overflow;
   logic [DROP_W-1:0]           r_drop;

   logic                        w_other;
   logic                        w_frame_valid;
   logic                        w_handshake;
   logic                        w_accept;
   logic                        w_complete;
   logic                        w_drop;
   logic                        w_other_free;
   logic                        w_swap;
   logic [LVL_W-1:0]            w_start;
   logic [DATA_W-1:0]           w_tail [HALF];
   logic [N_POINTS*DATA_W-1:0]  w_frame_data;

   channel_mixer #(
      .DATA_W (DATA_W)
   ) u_mixer (
      .clk      (Clk),
      .rst      (Reset),
      .i_valid  (bus.in_valid),
      .i_left   (bus.in_left),
      .i_right  (bus.in_right),
      .i_mode   (bus.ch_mode),
      .o_valid  (w_mix_valid),
      .o_sample (w_mix_sample)
   );

   // Banks fill and drain in strict alternation, so the read pointer always
   // names the oldest FULL bank and the other bank is never FILLING at completion.
   always_comb begin
      w_other       = ~r_wr_ptr;
      w_frame_valid = (r_state[r_rd_ptr] == FULL);
      w_handshake   = w_frame_valid && bus.frame_ready;
      w_accept      = w_mix_valid && !r_pending;
      w_drop        = w_mix_valid && r_pending;
      w_complete    = w_accept && (r_wr_idx == LVL_W'(N_POINTS - 1));
      w_other_free  = (r_state[w_other] == EMPTY) ||
                      (w_handshake && (r_rd_ptr == w_other));
      w_swap        = (w_complete && w_other_free) || (r_pending && w_handshake);
      w_start       = bus.overlap_en ? LVL_W'(HALF) : '0;
   end

   // Upper half of the completing bank, including a last sample landing this edge
   always_comb begin
      for (int i = 0; i < HALF; i++) begin
         w_tail[i] = r_bank[r_wr_ptr][HALF + i];
      end
      if (w_complete) begin
         w_tail[HALF-1] = w_mix_sample;
      end
   end

   // Presented frame is the read bank, lane 0 oldest
   always_comb begin
      w_frame_data = '0;
      for (int i = 0; i < N_POINTS; i++) begin
         w_frame_data[i*DATA_W +: DATA_W] = r_bank[r_rd_ptr][i];
      end
   end

   // Bank storage, bank states, pointers, pending swap and counters
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int b = 0; b < 2; b++) begin
            r_state[b] <= EMPTY;
            for (int i = 0; i < N_POINTS; i++) begin
               r_bank[b][i] <= '0;
            end
         end
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_pending  <= 1'b0;
         r_wr_idx   <= '0;
         r_seq      <= '0;
         r_overflow <= 1'b0;
         r_drop     <= '0;
      end else begin
         if (w_accept) begin
            r_bank[r_wr_ptr][r_wr_idx[IDX_W-1:0]] <= w_mix_sample;
            if (w_complete) begin
               r_state[r_wr_ptr] <= FULL;
               if (!w_other_free) begin
                  // Nowhere to write until the older frame is taken
                  r_pending <= 1'b1;
                  r_wr_idx  <= LVL_W'(N_POINTS);
               end
            end else begin
               r_state[r_wr_ptr] <= FILLING;
               r_wr_idx          <= r_wr_idx + 1'b1;
            end
         end

         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop != '1) begin
               r_drop <= r_drop + 1'b1;
            end
         end

         if (w_handshake) begin
            r_state[r_rd_ptr] <= EMPTY;
            r_rd_ptr          <= ~r_rd_ptr;
            r_seq             <= r_seq + 1'b1;
         end

         // Placed after the handshake so the freed bank's new state wins
         if (w_swap) begin
            r_wr_ptr  <= w_other;
            r_pending <= 1'b0;
            r_wr_idx  <= w_start;
            if (bus.overlap_en) begin
               r_state[w_other] <= FILLING;
               for (int i = 0; i < HALF; i++) begin
                  r_bank[w_other][i] <= w_tail[i];
               end
            end else begin
               r_state[w_other] <= EMPTY;
            end
         end
      end
   end

   assign bus.frame_valid = w_frame_valid;
   assign bus.frame_data  = w_frame_data;
   assign bus.frame_seq   = r_seq;
   assign bus.overflow    = r_overflow;
   assign bus.drop_count  = r_drop;
   assign bus.fill_level  = r_wr_idx;

endmodule : fft_frame_buffer
`default_nettype wire

// File: tb/tb_fft_frame_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : tb_fft_frame_buffer                                          |
// | Directed self-checking bench for fft_frame_buffer.                    |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module tb_fft_frame_buffer;

   localparam int DW = 24;
   localparam int NP = 16;
   localparam int FW = DW * NP;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   fft_frame_buffer_if #(.DATA_W(DW), .N_POINTS(NP), .SEQ_W(8), .DROP_W(16)) bus_a ();
   fft_frame_buffer_if #(.DATA_W(DW), .N_POINTS(NP), .SEQ_W(8), .DROP_W(4))  bus_b ();

   fft_frame_buffer #(.DATA_W(DW), .N_POINTS(NP), .SEQ_W(8), .DROP_W(16)) u_dut_a (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus_a)
   );

   fft_frame_buffer #(.DATA_W(DW), .N_POINTS(NP), .SEQ_W(8), .DROP_W(4)) u_dut_b (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus_b)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FW-1:0] ramp(input int first);
      logic [FW-1:0] v;
      v = '0;
      for (int i = 0; i < NP; i++) v[i*DW +: DW] = DW'(first + i);
      return v;
   endfunction

   task automatic drive_a(input logic v, input logic [DW-1:0] l, input logic [DW-1:0] r);
      bus_a.in_valid = v;
      bus_a.in_left  = l;
      bus_a.in_right = r;
   endtask

   task automatic drive_b(input logic v, input logic [DW-1:0] l);
      bus_b.in_valid = v;
      bus_b.in_left  = l;
      bus_b.in_right = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [FW-1:0] exp4;
      drive_a(1'b0, '0, '0);
      drive_b(1'b0, '0);
      bus_a.ch_mode = 2'd0; bus_a.overlap_en = 1'b0; bus_a.frame_ready = 1'b0;
      bus_b.ch_mode = 2'd0; bus_b.overlap_en = 1'b0; bus_b.frame_ready = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_valid", bus_a.frame_valid, 0);
      chk("rst_fill",  bus_a.fill_level,  0);
      chk("rst_ovf",   bus_a.overflow,    0);
      chk("rst_drop",  bus_a.drop_count,  0);
      chk("rst_seq",   bus_a.frame_seq,   0);
      chk("rst_data",  bus_a.frame_data,  0);

      // Basic frame, left channel, no overlap, consumer always ready
      bus_a.frame_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         drive_a(1'b1, DW'(k), DW'(999));
         tick();
      end
      drive_a(1'b0, '0, '0);
      chk("t1_early", bus_a.frame_valid, 0);
      tick();
      chk("t1_valid", bus_a.frame_valid, 1);
      chk("t1_data",  bus_a.frame_data,  ramp(0));
      chk("t1_seq",   bus_a.frame_seq,   0);
      chk("t1_fill",  bus_a.fill_level,  0);
      tick();
      chk("t1_seq_next",   bus_a.frame_seq,   1);
      chk("t1_valid_next", bus_a.frame_valid, 0);

      // Consumer stalled: two frames held, third frame dropped
      do_reset();
      bus_a.frame_ready = 1'b0;
      for (int k = 0; k < 48; k++) begin
         drive_a(1'b1, DW'(200 + k), '0);
         tick();
      end
      drive_a(1'b0, '0, '0);
      tick();
      tick();
      chk("t2_valid", bus_a.frame_valid, 1);
      chk("t2_seq0",  bus_a.frame_seq,   0);
      chk("t2_data0", bus_a.frame_data,  ramp(200));
      chk("t2_ovf",   bus_a.overflow,    1);
      chk("t2_drop",  bus_a.drop_count,  16);
      chk("t2_fill",  bus_a.fill_level,  16);
      tick();
      chk("t2_hold",  bus_a.frame_data,  ramp(200));
      bus_a.frame_ready = 1'b1;
      tick();
      chk("t2_seq1",   bus_a.frame_seq,   1);
      chk("t2_valid1", bus_a.frame_valid, 1);
      chk("t2_data1",  bus_a.frame_data,  ramp(216));
      chk("t2_fill1",  bus_a.fill_level,  0);
      tick();
      chk("t2_seq2",   bus_a.frame_seq,   2);
      chk("t2_valid2", bus_a.frame_valid, 0);

      // Reset mid-frame with a sample still in the mixer
      for (int k = 0; k < 7; k++) begin
         drive_a(1'b1, DW'(50 + k), '0);
         tick();
      end
      drive_a(1'b0, '0, '0);
      chk("t5_fill_pre", bus_a.fill_level, 6);
      chk("t5_ovf_pre",  bus_a.overflow,   1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("t5_valid", bus_a.frame_valid, 0);
      chk("t5_fill",  bus_a.fill_level,  0);
      chk("t5_ovf",   bus_a.overflow,    0);
      chk("t5_drop",  bus_a.drop_count,  0);
      for (int k = 0; k < 16; k++) begin
         drive_a(1'b1, DW'(100 + k), '0);
         tick();
      end
      drive_a(1'b0, '0, '0);
      tick();
      chk("t5_fvalid", bus_a.frame_valid, 1);
      chk("t5_seq",    bus_a.frame_seq,   0);
      chk("t5_data",   bus_a.frame_data,  ramp(100));
      tick();

      // 50% overlap
      do_reset();
      bus_a.overlap_en  = 1'b1;
      bus_a.frame_ready = 1'b1;
      for (int k = 0; k < 24; k++) begin
         drive_a(1'b1, DW'(k), '0);
         tick();
         if (k == 16) begin
            chk("t3_f0_valid", bus_a.frame_valid, 1);
            chk("t3_f0_data",  bus_a.frame_data,  ramp(0));
            chk("t3_fill",     bus_a.fill_level,  8);
         end
      end
      drive_a(1'b0, '0, '0);
      tick();
      chk("t3_f1_valid", bus_a.frame_valid, 1);
      chk("t3_f1_seq",   bus_a.frame_seq,   1);
      chk("t3_f1_data",  bus_a.frame_data,  ramp(8));
      bus_a.overlap_en = 1'b0;
      tick();

      // Channel modes, changed per sample
      do_reset();
      bus_a.frame_ready = 1'b0;
      bus_a.ch_mode = 2'd2;
      drive_a(1'b1, DW'(100), 24'hFFFFCE);
      tick();
      drive_a(1'b1, 24'hFFFFFF, '0);
      tick();
      bus_a.ch_mode = 2'd1;
      drive_a(1'b1, DW'(5), DW'(7));
      tick();
      bus_a.ch_mode = 2'd3;
      for (int k = 3; k < 16; k++) begin
         drive_a(1'b1, DW'(k), 24'h000123);
         tick();
      end
      drive_a(1'b0, '0, '0);
      tick();
      exp4 = ramp(0);
      exp4[0  +: DW] = 24'd25;
      exp4[DW +: DW] = 24'hFFFFFF;
      exp4[2*DW +: DW] = 24'd7;
      chk("t4_valid", bus_a.frame_valid, 1);
      chk("t4_data",  bus_a.frame_data,  exp4);
      bus_a.ch_mode = 2'd0;
      bus_a.frame_ready = 1'b1;
      tick();
      bus_a.frame_ready = 1'b0;

      // Completion of one bank on the same edge the other bank is taken
      do_reset();
      for (int k = 0; k < 32; k++) begin
         drive_a(1'b1, DW'(300 + k), '0);
         tick();
      end
      drive_a(1'b0, '0, '0);
      bus_a.frame_ready = 1'b1;
      tick();
      bus_a.frame_ready = 1'b0;
      chk("t7_seq",   bus_a.frame_seq,   1);
      chk("t7_valid", bus_a.frame_valid, 1);
      chk("t7_data",  bus_a.frame_data,  ramp(316));
      chk("t7_fill",  bus_a.fill_level,  0);
      chk("t7_ovf",   bus_a.overflow,    0);
      drive_a(1'b1, DW'(77), '0);
      tick();
      drive_a(1'b0, '0, '0);
      tick();
      chk("t7_fill_next", bus_a.fill_level, 1);

      // Drop counter saturation on the narrow-counter instance
      do_reset();
      for (int k = 0; k < 60; k++) begin
         drive_b(1'b1, DW'(k));
         tick();
      end
      drive_b(1'b0, '0);
      tick();
      chk("t6_drop",  bus_b.drop_count,  15);
      chk("t6_ovf",   bus_b.overflow,    1);
      chk("t6_valid", bus_b.frame_valid, 1);
      chk("t6_data",  bus_b.frame_data,  ramp(0));
      bus_b.frame_ready = 1'b1;
      tick();
      chk("t6_seq1",      bus_b.frame_seq,  1);
      chk("t6_drop_hold", bus_b.drop_count, 15);
      chk("t6_fill",      bus_b.fill_level, 0);
      bus_b.frame_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_fft_frame_buffer
`default_nettype wire
